// File: rtl/nibble_demux_packer_if.sv
// nibble_demux_packer_if: nibble input stream and frame output bundle.
// slave is the packer side, master drives nibbles and accepts frames.
interface nibble_demux_packer_if #(
   parameter int SLOTS = 256,
   parameter int CNT_W = $clog2(SLOTS) + 1
);
   logic [3:0]         key;
   logic               in_valid;
   logic               in_ready;
   logic [3:0]         in_nib;
   logic               in_last;
   logic               frame_valid;
   logic               frame_ready;
   logic [4*SLOTS-1:0] frame_data;
   logic [CNT_W-1:0]   frame_count;

   modport slave (
      input  key,
      input  in_valid,
      output in_ready,
      input  in_nib,
      input  in_last,
      output frame_valid,
      input  frame_ready,
      output frame_data,
      output frame_count
   );

   modport master (
      output key,
      output in_valid,
      input  in_ready,
      output in_nib,
      output in_last,
      input  frame_valid,
      output frame_ready,
      input  frame_data,
      input  frame_count
   );
endinterface

// File: rtl/nibble_demux_packer.sv
// nibble_demux_packer: decodes key-XORed nibbles into a wide frame
// and hands each completed frame downstream over valid/ready.
module nibble_demux_packer #(
   parameter int SLOTS = 256,
   parameter int CNT_W = $clog2(SLOTS) + 1
) (
   input logic                  clk,
   input logic                  reset,
   nibble_demux_packer_if.slave bus
);
   localparam int IDX_W = $clog2(4 * SLOTS);

   localparam logic FILL = 1'b0;
   localparam logic HOLD = 1'b1;

   localparam logic [CNT_W-1:0] LAST_SLOT =
      CNT_W'(SLOTS - 1);

   logic               state;
   logic [CNT_W-1:0]   cnt;
   logic [4*SLOTS-1:0] data;
   logic [IDX_W-1:0]   idx;
   logic [3:0]         dec;
   logic               accept;
   logic               closing;
   logic               xfer;

   assign bus.in_ready    = (state == FILL);
   assign bus.frame_valid = (state == HOLD);
   assign bus.frame_data  = data;
   assign bus.frame_count = cnt;

   assign accept  = bus.in_valid &&
                    (state == FILL);
   assign xfer    = bus.frame_ready &&
                    (state == HOLD);
   assign closing = (cnt == LAST_SLOT) ||
                    bus.in_last;
   assign dec     = bus.in_nib ^ bus.key;

   // cnt doubles as the write pointer while filling
   assign idx = IDX_W'(cnt) << 2;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= FILL;
         cnt   <= '0;
         data  <= '0;
      end else begin
         unique case (1'b1)
            accept: begin
               data[idx +: 4] <= dec;
               cnt            <= cnt + 1'b1;
               if (closing)
                  state <= HOLD;
            end
            xfer: begin
               state <= FILL;
               cnt   <= '0;
               data  <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_demux_packer.sv
// tb_nibble_demux_packer: directed stimulus against a queue model
// of the frame contents, checked every cycle plus literal pins.
module tb_nibble_demux_packer;
   localparam int SLOTS = 256;
   localparam int CNT_W = 9;
   localparam int W     = 4 * SLOTS;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   nibble_demux_packer_if #(
      .SLOTS(SLOTS),
      .CNT_W(CNT_W)
   ) bus ();

   nibble_demux_packer #(
      .SLOTS(SLOTS),
      .CNT_W(CNT_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nbad = 0;

   logic [3:0] mq[$];
   bit         mhold = 1'b0;
   bit         live  = 1'b0;

   function automatic logic [W-1:0] pack();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < mq.size(); i++)
         v[4*i +: 4] = mq[i];
      return v;
   endfunction

   task automatic chk(string name,
                      logic [W-1:0] got,
                      logic [W-1:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s got=%0h want=%0h",
                  name, got, exp);
      end
   endtask

   function automatic logic [3:0] slot(int k);
      return bus.frame_data[4*k +: 4];
   endfunction

   // model: a frame is simply the list of decoded accepted nibbles
   always @(posedge clk) begin
      live = 1'b1;
      if (!reset) begin
         mq.delete();
         mhold = 1'b0;
      end else if (mhold) begin
         if (bus.frame_ready) begin
            mq.delete();
            mhold = 1'b0;
         end
      end else if (bus.in_valid) begin
         mq.push_back(bus.in_nib ^ bus.key);
         if (mq.size() == SLOTS || bus.in_last)
            mhold = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk("in_ready", W'(bus.in_ready),
             W'(!mhold));
         chk("frame_valid", W'(bus.frame_valid),
             W'(mhold));
         chk("frame_data", bus.frame_data, pack());
         chk("frame_count", W'(bus.frame_count),
             W'(mq.size()));
      end
   end

   task automatic beat(logic [3:0] n,
                       logic [3:0] k,
                       logic l);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_nib   = n;
      bus.key      = k;
      bus.in_last  = l;
   endtask

   task automatic idle(int c);
      repeat (c) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in_last  = 1'b0;
      end
   endtask

   logic [W-1:0] snap;

   initial begin
      bus.key         = 4'h0;
      bus.in_valid    = 1'b0;
      bus.in_nib      = 4'h0;
      bus.in_last     = 1'b0;
      bus.frame_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", W'(bus.in_ready), W'(1));
      chk("rst_fvalid", W'(bus.frame_valid), W'(0));
      chk("rst_data", bus.frame_data, '0);
      chk("rst_count", W'(bus.frame_count), W'(0));
      reset = 1'b1;

      // full frame, constant key
      bus.frame_ready = 1'b1;
      for (int k = 0; k < SLOTS; k++)
         beat(k[3:0], 4'hA, 1'b0);
      idle(1);
      chk("full_fvalid", W'(bus.frame_valid), W'(1));
      chk("full_count", W'(bus.frame_count), W'(256));
      chk("full_s0", W'(slot(0)), W'(4'hA));
      chk("full_s1", W'(slot(1)), W'(4'hB));
      chk("full_s255", W'(slot(255)), W'(4'h5));
      idle(1);
      chk("turn_ready", W'(bus.in_ready), W'(1));
      chk("turn_data", bus.frame_data, '0);

      // early close
      bus.frame_ready = 1'b0;
      beat(4'h1, 4'h0, 1'b0);
      beat(4'h2, 4'h0, 1'b0);
      beat(4'h3, 4'h0, 1'b1);
      idle(1);
      chk("early_data", bus.frame_data, W'(12'h321));
      chk("early_count", W'(bus.frame_count), W'(3));
      bus.frame_ready = 1'b1;
      idle(1);
      bus.frame_ready = 1'b0;

      // backpressure with in_valid held high
      for (int k = 0; k < SLOTS; k++)
         beat(k[3:0], 4'hA, 1'b0);
      @(negedge clk);
      snap         = bus.frame_data;
      bus.in_nib   = 4'hF;
      bus.in_last  = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("bp_data", bus.frame_data, snap);
         chk("bp_ready", W'(bus.in_ready), W'(0));
      end
      bus.frame_ready = 1'b1;
      @(negedge clk);
      bus.frame_ready = 1'b0;
      idle(1);
      chk("bp_next_s0", W'(slot(0)), W'(4'h5));
      chk("bp_next_cnt", W'(bus.frame_count), W'(1));
      beat(4'h0, 4'h0, 1'b1);
      idle(1);
      bus.frame_ready = 1'b1;
      idle(1);

      // reset mid-frame
      for (int k = 0; k < 100; k++)
         beat(k[3:0], 4'h3, 1'b0);
      idle(1);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_fvalid", W'(bus.frame_valid), W'(0));
      chk("abort_count", W'(bus.frame_count), W'(0));
      reset = 1'b1;
      bus.frame_ready = 1'b0;
      beat(4'h7, 4'h0, 1'b0);
      beat(4'h9, 4'h0, 1'b1);
      idle(1);
      chk("rst2_count", W'(bus.frame_count), W'(2));
      chk("rst2_data", bus.frame_data, W'(8'h97));
      bus.frame_ready = 1'b1;
      idle(1);
      bus.frame_ready = 1'b0;

      // alternating key with idle gaps
      for (int i = 0; i < 8; i++) begin
         beat(4'(i + 1),
              (i % 2 != 0) ? 4'hC : 4'h5,
              i == 7);
         if (i % 2 != 0)
            idle(1);
      end
      idle(1);
      chk("gap_data", bus.frame_data, W'(32'h42A086E4));
      chk("gap_count", W'(bus.frame_count), W'(8));
      bus.frame_ready = 1'b1;
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nbad);
      $finish;
   end
endmodule

// File: doc/nibble_demux_packer.md
# nibble_demux_packer

Write-side counterpart of the nibble select/XOR output path. It accepts a stream of key-XORed 4-bit nibbles over a valid/ready handshake and recovers each data nibble as `in_nib ^ key`. It scatters the recovered nibbles into consecutive 4-bit slots of a wide frame register, using the same slot mapping the read-side mux uses: slot k occupies bits [4k+3:4k]. When the frame completes, it presents the frame downstream on a second valid/ready handshake.

## Interface
- Parameter `SLOTS`, default 256: nibble slots per frame. Frame width is 4*SLOTS bits (1024 at default).
- Parameter `CNT_W`, default $clog2(SLOTS)+1: width of the slot counter and of `frame_count`.
- `clk`, input, 1: the single clock. Everything is sampled on its rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `key`, input, 4: decode key, sampled on each accepted input beat.
- `in_valid`, input, 1: input beat present.
- `in_ready`, output, 1: block can accept an input beat.
- `in_nib`, input, 4: encoded nibble.
- `in_last`, input, 1: this beat closes the frame early.
- `frame_valid`, output, 1: a completed frame is held on the outputs.
- `frame_ready`, input, 1: downstream accepts the frame.
- `frame_data`, output, 4*SLOTS: assembled frame.
- `frame_count`, output, CNT_W: number of slots written in the held frame, range 1..SLOTS.

## Operation
- Two states: FILL and HOLD.
- An input beat is accepted when `in_valid && in_ready`.
- **FILL**
  - `in_ready`=1, `frame_valid`=0.
  - On each accepted beat, `frame_data[4*wr_ptr +: 4]` is loaded with `in_nib ^ key`.
  - `wr_ptr` and the count then increment.
  - The state moves to HOLD after the accepted beat if either:
    - `wr_ptr == SLOTS-1` (frame full), or
    - `in_last`=1.
- **HOLD**
  - `in_ready`=0, `frame_valid`=1.
  - `frame_data` and `frame_count` are stable.
  - `in_valid` is ignored.
  - The frame transfers when `frame_valid && frame_ready`. On that cycle's edge:
    - the state returns to FILL;
    - `frame_data` clears to 0;
    - `wr_ptr` and `frame_count` clear to 0.
- Early-closed frames: slots that were never written read 0.
- Wrap-around:
  - `wr_ptr` never exceeds SLOTS-1. The full condition forces HOLD before any further write.
  - `frame_count` reaches SLOTS exactly on a full frame; CNT_W is wide enough to hold this value.
- Simultaneous full and `in_last`: the result is the same as full alone. The state goes to HOLD with count SLOTS.
- Slots are never written twice within a frame. There is no random-access write.
- Arithmetic:
  - The decode is a 4-bit XOR with no carry.
  - `frame_count` is an unsigned count of accepted beats in the current frame.
- Reset (`reset`=0 at a clock edge), including mid-frame or during HOLD:
  - state = FILL, `wr_ptr`=0, `frame_data`=0, `frame_count`=0;
  - `frame_valid`=0, `in_ready`=1 from the cycle after that edge;
  - any partial frame is discarded and no frame is emitted for it.

## Timing
- Reset values: `in_ready`=1, `frame_valid`=0, `frame_data`=0, `frame_count`=0.
- `in_ready` and `frame_valid` are decoded from the registered state only. There is no combinational path from `in_valid` or `frame_ready`.
- Input throughput: 1 nibble/cycle in FILL.
- Latency: `frame_valid` rises in the cycle after the closing beat is accepted.
- Turnaround: if `frame_ready`=1 in the first HOLD cycle, the frame transfers in that cycle and `in_ready`=1 in the next cycle. Minimum HOLD duration is 1 cycle.
- Full-frame period at 100% `in_valid` and `frame_ready`: SLOTS+1 cycles.
- Changes to `key` take effect per beat. There is no key latching across beats.
- Outputs must stay stable while `frame_valid`=1 and `frame_ready`=0, for any number of cycles.

## Test plan
1. **Reset values.** Hold `reset`=0 for 2 cycles, then release → `in_ready`=1, `frame_valid`=0, `frame_data`=0, `frame_count`=0.
2. **Full frame at constant key.** `key`=4'hA; stream 256 beats with `in_nib`=k[3:0] for k=0..255, `frame_ready`=1 → `frame_valid` rises 1 cycle after beat 255; `frame_data[4k+3:4k]`=k[3:0]^4'hA; `frame_count`=256; frame transfers in the first HOLD cycle; `in_ready`=1 on the following cycle.
3. **Early close.** `key`=0; send 3 beats with `in_nib`=4'h1, 4'h2, 4'h3, with `in_last`=1 on the third → `frame_data[11:0]`=12'h321, all other bits 0, `frame_count`=3.
4. **Backpressure.** Full frame as in scenario 2 with `frame_ready`=0 for 10 cycles; drive `in_valid`=1 with `in_nib`=4'hF throughout → `in_ready`=0, `frame_data` unchanged across all 10 cycles, no write occurs. After `frame_ready` is raised, the next frame's slot 0 holds 4'hF^`key`.
5. **Reset mid-frame.** Send 100 beats, pulse `reset`=0 for 1 cycle, then send 2 beats with `in_last`=1 → the emitted frame has `frame_count`=2; only slots 0–1 are nonzero when `in_nib`^`key` is nonzero; no frame is emitted for the aborted 100 beats.
6. **Per-beat key and in_valid gaps.** Alternate `key` between 4'h5 and 4'hC on successive beats; toggle `in_valid` with idle gaps → each slot k equals `in_nib_k ^ key_k`; idle cycles write nothing and do not advance `wr_ptr`.
